// File: rtl/soc_exc_pkg.sv
// Shared definitions for the exception controller: FSM states, cause codes
// and address-step constants.
package soc_exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT,
    ST_HANDLER,
    ST_RETURN,
    ST_HALT
  } exc_state_t;

  localparam logic [3:0] EXC_NONE = 4'd0;
  localparam logic [3:0] EXC_DIV0 = 4'd1;

  localparam int unsigned VEC_SHIFT    = 4;
  localparam int unsigned ERET_PC_STEP = 4;

endpackage

// File: rtl/exception_controller.sv
// Exception responder: captures the faulting PC/cause, flushes the pipeline,
// vectors fetch to the cause handler, returns on eret and halts on double fault.
module exception_controller
  import soc_exc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] VECTOR_BASE  = 32'h0000_0100,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exception,
  input  logic [3:0]      exception_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            eret,
  output logic            flush,
  output logic            stall,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] epc,
  output logic [3:0]      cause,
  output logic            in_handler,
  output logic            double_fault
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

  exc_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Outputs are assigned for the state being entered, so each one is a plain
  // register that is valid for the whole cycle spent in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      flush        <= 1'b0;
      stall        <= 1'b0;
      pc_redirect  <= 1'b0;
      redirect_pc  <= '0;
      epc          <= '0;
      cause        <= '0;
      in_handler   <= 1'b0;
      double_fault <= 1'b0;
    end else begin
      flush       <= 1'b0;
      stall       <= 1'b0;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
      in_handler  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (exception) begin
            epc   <= exc_pc;
            cause <= exception_code;
            cnt   <= CNT_W'(1);
            state <= ST_FLUSH;
            flush <= 1'b1;
            stall <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt == CNT_W'(FLUSH_CYCLES)) begin
            state       <= ST_REDIRECT;
            pc_redirect <= 1'b1;
            redirect_pc <= VECTOR_BASE + (XLEN'(cause) << VEC_SHIFT);
          end else begin
            cnt   <= cnt + CNT_W'(1);
            flush <= 1'b1;
            stall <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          state      <= ST_HANDLER;
          in_handler <= 1'b1;
        end
        ST_HANDLER: begin
          if (exception) begin
            double_fault <= 1'b1;
            state        <= ST_HALT;
            flush        <= 1'b1;
            stall        <= 1'b1;
          end else if (eret) begin
            state       <= ST_RETURN;
            flush       <= 1'b1;
            pc_redirect <= 1'b1;
            redirect_pc <= epc + XLEN'(ERET_PC_STEP);
          end else begin
            in_handler <= 1'b1;
          end
        end
        ST_RETURN: begin
          state <= ST_IDLE;
        end
        ST_HALT: begin
          flush <= 1'b1;
          stall <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exception_controller.sv
// Self-checking bench for exception_controller: directed table, corner-case
// sequences and random stimulus against a transaction-level reference model.
module tb_exception_controller;

  localparam logic [31:0] VB = 32'h0000_0100;
  localparam int          FC = 2;

  typedef struct packed {
    logic        flush;
    logic        stall;
    logic        pcr;
    logic [31:0] rpc;
    logic        inh;
    logic        df;
    logic [31:0] epc;
    logic [3:0]  cause;
  } outs_t;

  typedef struct {
    logic        e;
    logic [3:0]  c;
    logic [31:0] pc;
    logic        r;
    outs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exception = 1'b0;
  logic [3:0]  exception_code = '0;
  logic [31:0] exc_pc = '0;
  logic        eret = 1'b0;
  logic        flush, stall, pc_redirect, in_handler, double_fault;
  logic [31:0] redirect_pc, epc;
  logic [3:0]  cause;

  int n_cmp = 0;
  int n_bad = 0;

  exception_controller #(
    .XLEN(32),
    .VECTOR_BASE(VB),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst(rst), .exception(exception), .exception_code(exception_code),
    .exc_pc(exc_pc), .eret(eret), .flush(flush), .stall(stall),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .epc(epc), .cause(cause),
    .in_handler(in_handler), .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  // Reference model: a trap is a scripted run of cycles; outside a script the
  // model is idle, in a handler, or halted.
  outs_t       sched[$];
  int          m_mode;   // 0 idle, 1 handler, 2 halted
  logic [31:0] m_epc;
  logic [3:0]  m_cause;
  logic        m_df;

  function automatic outs_t o(logic f, logic s, logic p, logic [31:0] rpc, logic i,
                              logic d, logic [31:0] pc, logic [3:0] c);
    o = {f, s, p, rpc, i, d, pc, c};
  endfunction

  function automatic outs_t mk(logic f, logic s, logic p, logic [31:0] rpc, logic i);
    mk = o(f, s, p, rpc, i, m_df, m_epc, m_cause);
  endfunction

  function automatic void model_reset();
    sched.delete();
    m_mode  = 0;
    m_epc   = '0;
    m_cause = '0;
    m_df    = 1'b0;
  endfunction

  function automatic outs_t model_step(logic e, logic [3:0] c, logic [31:0] pc, logic r);
    outs_t res;
    if (sched.size() > 0) return sched.pop_front();
    case (m_mode)
      0: begin
        if (e) begin
          m_epc   = pc;
          m_cause = c;
          for (int i = 0; i < FC; i++) sched.push_back(mk(1, 1, 0, 0, 0));
          sched.push_back(mk(0, 0, 1, VB + 32'(c) * 32'd16, 0));
          sched.push_back(mk(0, 0, 0, 0, 1));
          m_mode = 1;
          res = sched.pop_front();
        end else res = mk(0, 0, 0, 0, 0);
      end
      1: begin
        if (e) begin
          m_df   = 1'b1;
          m_mode = 2;
          res = mk(1, 1, 0, 0, 0);
        end else if (r) begin
          res = mk(1, 0, 1, m_epc + 32'd4, 0);
          sched.push_back(mk(0, 0, 0, 0, 0));
          m_mode = 0;
        end else res = mk(0, 0, 0, 0, 1);
      end
      default: res = mk(1, 1, 0, 0, 0);
    endcase
    return res;
  endfunction

  function automatic outs_t dut_outs();
    dut_outs = {flush, stall, pc_redirect, redirect_pc, in_handler, double_fault, epc, cause};
  endfunction

  task automatic chk(string name, outs_t act, outs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got f=%b s=%b pcr=%b rpc=%h inh=%b df=%b epc=%h cause=%h, want f=%b s=%b pcr=%b rpc=%h inh=%b df=%b epc=%h cause=%h",
               name, act.flush, act.stall, act.pcr, act.rpc, act.inh, act.df, act.epc, act.cause,
               exp.flush, exp.stall, exp.pcr, exp.rpc, exp.inh, exp.df, exp.epc, exp.cause);
    end
  endtask

  // One clock: drive inputs, advance, sample 1 time unit after the edge and
  // compare against the model.
  task automatic cyc(logic e, logic [3:0] c, logic [31:0] pc, logic r, string name);
    outs_t m;
    exception      = e;
    exception_code = c;
    exc_pc         = pc;
    eret           = r;
    @(posedge clk);
    m = model_step(e, c, pc, r);
    #1;
    chk(name, dut_outs(), m);
  endtask

  task automatic idle(string name);
    cyc(0, 0, 0, 0, name);
  endtask

  task automatic async_reset(string name);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk(name, dut_outs(), '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 4'd1, 32'h40, 0, o(1, 1, 0, 0, 0, 0, 32'h40, 1)};
    tbl[1] = '{1, 4'd5, 32'h80, 0, o(1, 1, 0, 0, 0, 0, 32'h40, 1)};
    tbl[2] = '{0, 4'd0, 32'h0,  0, o(0, 0, 1, 32'h110, 0, 0, 32'h40, 1)};
    tbl[3] = '{0, 4'd0, 32'h0,  1, o(0, 0, 0, 0, 1, 0, 32'h40, 1)};
    tbl[4] = '{0, 4'd0, 32'h0,  0, o(0, 0, 0, 0, 1, 0, 32'h40, 1)};
    tbl[5] = '{0, 4'd0, 32'h0,  1, o(1, 0, 1, 32'h44, 0, 0, 32'h40, 1)};
    tbl[6] = '{1, 4'd3, 32'h200, 0, o(0, 0, 0, 0, 0, 0, 32'h40, 1)};
    tbl[7] = '{0, 4'd0, 32'h0,  1, o(0, 0, 0, 0, 0, 0, 32'h40, 1)};
    tbl[8] = '{0, 4'd0, 32'h0,  0, o(0, 0, 0, 0, 0, 0, 32'h40, 1)};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dut_outs(), '0);
    rst = 1'b0;

    // eret in IDLE is ignored, then the div-by-zero trap and return.
    cyc(0, 0, 0, 1, "eret_idle");
    chk("eret_idle_tbl", dut_outs(), '0);
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].e, tbl[i].c, tbl[i].pc, tbl[i].r, $sformatf("tbl_model_%0d", i));
      chk($sformatf("tbl_%0d", i), dut_outs(), tbl[i].exp);
    end

    // Wrap of epc+4 and back-to-back trap in the first IDLE cycle after RETURN.
    cyc(1, 4'd0, 32'hFFFF_FFFC, 0, "wrap_trap");
    idle("wrap_f2");
    idle("wrap_redir");
    chk("wrap_vec", dut_outs(), o(0, 0, 1, 32'h100, 0, 0, 32'hFFFF_FFFC, 0));
    idle("wrap_h");
    cyc(0, 0, 0, 1, "wrap_eret");
    chk("wrap_ret_pc", dut_outs(), o(1, 0, 1, 32'h0, 0, 0, 32'hFFFF_FFFC, 0));
    idle("b2b_idle");
    cyc(1, 4'd7, 32'h500, 0, "b2b_trap");
    chk("b2b_capture", dut_outs(), o(1, 1, 0, 0, 0, 0, 32'h500, 7));
    idle("b2b_f2");
    idle("b2b_redir");
    chk("b2b_vec", dut_outs(), o(0, 0, 1, 32'h170, 0, 0, 32'h500, 7));
    idle("b2b_h");

    // Double fault: exception and eret together in HANDLER.
    cyc(1, 4'd2, 32'h1000, 1, "df_trap");
    chk("df_noise", dut_outs(), o(1, 1, 0, 0, 0, 1, 32'h500, 7));
    for (int i = 0; i < 4; i++) begin
      cyc(i[0], 4'd9, 32'h2000, 1, $sformatf("df_hold_%0d", i));
      chk($sformatf("df_hold_tbl_%0d", i), dut_outs(), o(1, 1, 0, 0, 0, 1, 32'h500, 7));
    end
    async_reset("df_reset");

    // Reset mid-FLUSH, then eret ignored and a new trap accepted.
    cyc(1, 4'd1, 32'h40, 0, "mf_trap");
    async_reset("mf_reset");
    cyc(0, 0, 0, 1, "mf_eret");
    chk("mf_eret_tbl", dut_outs(), '0);
    cyc(1, 4'd4, 32'h300, 0, "mf_new");
    chk("mf_new_tbl", dut_outs(), o(1, 1, 0, 0, 0, 0, 32'h300, 4));
    idle("mf_f2");
    idle("mf_redir");
    chk("mf_vec", dut_outs(), o(0, 0, 1, 32'h140, 0, 0, 32'h300, 4));

    // Random stimulus against the model; leave a halt by resetting.
    begin
      int halted = 0;
      for (int i = 0; i < 600; i++) begin
        if (m_mode == 2) halted++;
        else halted = 0;
        if (halted > 3) begin
          async_reset("rnd_reset");
          halted = 0;
        end else begin
          cyc($urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)),
              $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0,
              $sformatf("rnd_%0d", i));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
